// File: rtl/hsi_tx_arbiter_if.sv
// Bundle between the byte clients, the HSI coder and the tx arbiter.
// The master modport is the arbiter side; the slave modport is the client/coder side.
interface hsi_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] data;
    logic [N_REQ-1:0]   ack;
    logic               cd_busy;
    logic [7:0]         cd_d;
    logic               cd_d_rdy;
    logic [2:0]         gnt_id;
    logic               active;
    logic               err_to;

    modport master (
        input  req, data, cd_busy,
        output ack, cd_d, cd_d_rdy, gnt_id, active, err_to
    );

    modport slave (
        output req, data, cd_busy,
        input  ack, cd_d, cd_d_rdy, gnt_id, active, err_to
    );
endinterface

// File: rtl/hsi_tx_arbiter.sv
// Round-robin scheduler sharing one HSI serial coder between N_REQ byte sources.
// Define HSI_TX_ARB_PRIO_EN to give req[0] strict priority over the round-robin group.
module hsi_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned GAP_TICKS    = 2,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    hsi_tx_arbiter_if.master bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StWaitBusy, StWaitDone, StGap} state_e;

    localparam logic [3:0] GapLast  = (GAP_TICKS == 0) ? 4'd0 : 4'(GAP_TICKS - 1);
    localparam logic [3:0] ToLast   = 4'(BUSY_TIMEOUT - 1);
    localparam logic [2:0] RrReset  = 3'(N_REQ - 1);

    state_e           state_q, state_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       gnt_id_q, gnt_id_d;
    logic [7:0]       cd_d_q, cd_d_d;
    logic             cd_d_rdy_q, cd_d_rdy_d;
    logic             err_to_q, err_to_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [3:0]       to_cnt_q, to_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;

    logic [7:0]       req_pad;
    logic [63:0]      data_pad;
    logic             found;
    logic [2:0]       win;
    logic [2:0]       idx;

    assign req_pad  = 8'(bus.req);
    assign data_pad = 64'(bus.data);

    // Winner search starts one past the last round-robin grant and wraps.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        idx   = 3'd0;
`ifdef HSI_TX_ARB_PRIO_EN
        if (req_pad[0]) begin
            found = 1'b1;
        end
        for (int unsigned k = 1; k < N_REQ; k++) begin
            idx = 3'((32'(rr_ptr_q) - 1 + k) % (N_REQ - 1) + 1);
            if (!found && req_pad[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`else
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = 3'((32'(rr_ptr_q) + k) % N_REQ);
            if (!found && req_pad[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_id_d   = gnt_id_q;
        cd_d_d     = cd_d_q;
        cd_d_rdy_d = cd_d_rdy_q;
        ack_d      = '0;
        err_to_d   = 1'b0;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        if (clk_en) begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        cd_d_d     = data_pad[{win, 3'b000} +: 8];
                        cd_d_rdy_d = 1'b1;
                        ack_d      = {{(N_REQ - 1){1'b0}}, 1'b1} << win;
                        gnt_id_d   = win;
`ifdef HSI_TX_ARB_PRIO_EN
                        if (win != 3'd0) rr_ptr_d = win;
`else
                        rr_ptr_d   = win;
`endif
                        state_d    = StLoad;
                    end
                end
                StLoad: begin
                    cd_d_rdy_d = 1'b0;
                    to_cnt_d   = 4'd0;
                    state_d    = StWaitBusy;
                end
                StWaitBusy: begin
                    if (bus.cd_busy) begin
                        state_d = StWaitDone;
                    end else if (to_cnt_q == ToLast) begin
                        err_to_d  = 1'b1;
                        gap_cnt_d = GapLast;
                        state_d   = StGap;
                    end else begin
                        to_cnt_d = to_cnt_q + 4'd1;
                    end
                end
                StWaitDone: begin
                    if (!bus.cd_busy) begin
                        if (GAP_TICKS == 0) begin
                            state_d = StIdle;
                        end else begin
                            gap_cnt_d = GapLast;
                            state_d   = StGap;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == 4'd0) state_d = StIdle;
                    else gap_cnt_d = gap_cnt_q - 4'd1;
                end
                default: begin
                    cd_d_rdy_d = 1'b0;
                    state_d    = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= RrReset;
            gnt_id_q   <= 3'd0;
            cd_d_q     <= 8'h00;
            cd_d_rdy_q <= 1'b0;
            ack_q      <= '0;
            err_to_q   <= 1'b0;
            to_cnt_q   <= 4'd0;
            gap_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_id_q   <= gnt_id_d;
            cd_d_q     <= cd_d_d;
            cd_d_rdy_q <= cd_d_rdy_d;
            ack_q      <= ack_d;
            err_to_q   <= err_to_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.cd_d     = cd_d_q;
    assign bus.cd_d_rdy = cd_d_rdy_q;
    assign bus.gnt_id   = gnt_id_q;
    assign bus.err_to   = err_to_q;
    assign bus.active   = (state_q != StIdle);
endmodule

// File: tb/tb_hsi_tx_arbiter.sv
// Scoreboard bench for hsi_tx_arbiter: a tick-level coder model, queued byte clients and a
// rule-based grant-order model; a monitor checks every ack / err_to pulse against the queue.
module tb_hsi_tx_arbiter;
    localparam int unsigned NReq   = 4;
    localparam int unsigned Gap    = 2;
    localparam int unsigned BusyTo = 4;
    localparam int          Frame  = 11;  // start + 8 data + parity + stop
`ifdef HSI_TX_ARB_PRIO_EN
    localparam bit Prio = 1'b1;
`else
    localparam bit Prio = 1'b0;
`endif

    typedef struct {
        bit       is_to;
        int       id;
        logic [7:0] bval;
        int       dt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b0;
    int   en_mode = 1;
    bit   coder_on = 1'b1;
    int   busy_cnt = 0;
    int   rdy_ticks = 0;
    int   tick_cnt = 0;
    int   last_ev_tick = 0;
    int   grants_seen = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   m_rr = NReq - 1;
    int   t_en;
    exp_t sb[$];
    exp_t e;
    logic [7:0] src_buf [NReq][8];
    int   src_len [NReq];
    int   src_pos [NReq];

    hsi_tx_arbiter_if #(.N_REQ(NReq)) bus ();

    hsi_tx_arbiter #(
        .N_REQ(NReq),
        .GAP_TICKS(Gap),
        .BUSY_TIMEOUT(BusyTo)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_en(clk_en),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    endtask

    // Coder: a load seen on a tick keeps the line busy for Frame ticks.
    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
        end else if (clk_en) begin
            if (bus.cd_d_rdy) rdy_ticks <= rdy_ticks + 1;
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            else if (bus.cd_d_rdy && coder_on) busy_cnt <= Frame;
        end
    end
    assign bus.cd_busy = (busy_cnt != 0);

    always @(posedge clk) if (clk_en) tick_cnt <= tick_cnt + 1;

    initial begin
        forever begin
            @(negedge clk);
            case (en_mode)
                0: clk_en = 1'b0;
                1: clk_en = 1'b1;
                default: clk_en = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Clients: present the head byte while any remain, advance on ack.
    initial begin
        logic [NReq-1:0]   r;
        logic [8*NReq-1:0] d;
        for (int i = 0; i < NReq; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        bus.req  = '0;
        bus.data = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NReq; i++)
                if (bus.ack[i] && src_pos[i] < src_len[i]) src_pos[i]++;
            r = '0;
            d = '0;
            for (int i = 0; i < NReq; i++) begin
                if (src_pos[i] < src_len[i]) begin
                    r[i]       = 1'b1;
                    d[8*i +: 8] = src_buf[i][src_pos[i]];
                end
            end
            bus.req  = r;
            bus.data = d;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.ack != 0 || bus.err_to) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", int'(bus.err_to), int'(e.is_to));
                    chk("on_tick", int'(clk_en), 1);
                    if (!e.is_to) begin
                        chk("ack", int'(bus.ack), 1 << e.id);
                        chk("gnt_id", int'(bus.gnt_id), e.id);
                        chk("cd_d", int'(bus.cd_d), int'(e.bval));
                        chk("cd_d_rdy", int'(bus.cd_d_rdy), 1);
                        chk("active", int'(bus.active), 1);
                        chk("loads_prev", rdy_ticks, grants_seen);
                        grants_seen++;
                    end else begin
                        chk("ack_on_timeout", int'(bus.ack), 0);
                    end
                    if (e.dt >= 0) chk("tick_spacing", tick_cnt - last_ev_tick, e.dt);
                    last_ev_tick = tick_cnt;
                end
            end
        end
    end

    function automatic int pick(input logic [NReq-1:0] m);
        if (Prio && m[0]) return 0;
        for (int k = 1; k <= NReq; k++) begin
            int c;
            c = (m_rr + k) % NReq;
            if (!(Prio && c == 0) && m[c]) return c;
        end
        return -1;
    endfunction

    // Expected grant sequence when every queued byte is pending at once.
    task automatic plan(input bit coder_ok);
        int left [NReq];
        int pos [NReq];
        logic [NReq-1:0] m;
        int dt;
        int w;
        dt = -1;
        for (int i = 0; i < NReq; i++) begin
            left[i] = src_len[i] - src_pos[i];
            pos[i]  = src_pos[i];
        end
        forever begin
            for (int i = 0; i < NReq; i++) m[i] = (left[i] > 0);
            if (m == 0) break;
            w = pick(m);
            sb.push_back('{1'b0, w, src_buf[w][pos[w]], dt});
            pos[w]++;
            left[w]--;
            if (!(Prio && w == 0)) m_rr = w;
            if (coder_ok) begin
                // arbitration + load + busy ticks + busy-low detect + gap
                dt = Frame + int'(Gap) + 3;
            end else begin
                sb.push_back('{1'b1, 0, 8'h00, int'(BusyTo) + 1});
                dt = int'(Gap) + 1;
            end
        end
    endtask

    task automatic load(input int i, input int n);
        for (int k = 0; k < n; k++) src_buf[i][k] = 8'($urandom);
        src_pos[i] = 0;
        src_len[i] = n;
    endtask

    function automatic bit pending();
        for (int i = 0; i < NReq; i++) if (src_pos[i] < src_len[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || pending()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_budget", int'(n < budget), 1);
    endtask

    task automatic settle();
        en_mode = 1;
        repeat (60) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, int'(bus.ack), 0);
        chk({tag, "_cd_d"}, int'(bus.cd_d), 0);
        chk({tag, "_cd_d_rdy"}, int'(bus.cd_d_rdy), 0);
        chk({tag, "_gnt_id"}, int'(bus.gnt_id), 0);
        chk({tag, "_active"}, int'(bus.active), 0);
        chk({tag, "_err_to"}, int'(bus.err_to), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // All four pending, each drops on ack: 0,1,2,3 from the reset pointer.
        for (int i = 0; i < NReq; i++) load(i, 1);
        plan(1'b1);
        drain(2000);

        // Single requester 2 with a fixed byte.
        load(2, 1);
        src_buf[2][0] = 8'hA5;
        plan(1'b1);
        drain(2000);

        // Requesters 0 and 2 held for two bytes each.
        load(0, 2);
        load(2, 2);
        plan(1'b1);
        drain(2000);

        // Coder never goes busy: timeout, gap, re-grant.
        settle();
        coder_on = 1'b0;
        load(0, 2);
        plan(1'b0);
        drain(2000);
        settle();
        coder_on = 1'b1;

        // Reset while the coder is mid-frame with 0 and 3 waiting.
        load(2, 1);
        plan(1'b1);
        drain(2000);
        repeat (6) @(negedge clk);
        load(0, 1);
        load(3, 1);
        m_rr = NReq - 1;
        plan(1'b1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk_reset_outputs("midframe_reset");
        @(negedge clk);
        rst = 1'b0;
        drain(2000);

        // Ticks withheld: nothing may move until clk_en returns.
        settle();
        en_mode = 0;
        repeat (2) @(negedge clk);
        load(1, 1);
        plan(1'b1);
        repeat (20) @(negedge clk);
        chk("frozen_sb_depth", sb.size(), 1);
        chk("frozen_active", int'(bus.active), 0);
        t_en = tick_cnt;
        en_mode = 1;
        drain(2000);
        chk("first_tick_grant", last_ev_tick, t_en + 1);

        // Random batches with sparse ticks.
        en_mode = 2;
        for (int r = 0; r < 6; r++) begin
            logic [NReq-1:0] m;
            m = NReq'($urandom_range(1, (1 << NReq) - 1));
            for (int i = 0; i < NReq; i++) if (m[i]) load(i, $urandom_range(1, 3));
            plan(1'b1);
            drain(5000);
        end

        settle();
        chk("loads_total", rdy_ticks, grants_seen);
        chk("sb_left", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
